// File: rtl/dram_rw_seq.sv
// Purpose : serial-address DRAM burst sequencer (write, read, write-then-verify)
//           over NCH one-bit chips.
// Latency : DONE at 1+L*(AW+T+1) cycles after acceptance (L=burst_len+1);
//           write-then-verify takes 1+L*(2*AW+TWR+TRD+2).
// Backpress: none; commands are taken only in IDLE, io_en is ignored while busy.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   io_en, io_model           command strobe and mode (01 wr, 10 rd, 11 wr+verify)
//   base_addr, burst_len      first address, word count minus one
//   wr_data                   write pattern seed, rotated left by word index
//   rd_data_in                sense-amp outputs from the chips
//   add_in, add_valid         serial address (MSB first) and shift enable
//   d_in, data_valid, wri_en  write word and its enables
//   rd_en, vsaen              read wordline and sense-amp enables
//   rd_data, rd_valid         last sensed word and its update strobe
//   wt_done, rd_done, busy    completion pulses and activity flag
//   err, mismatch_cnt         verify mismatch flag and saturating count
module dram_rw_seq #(
  parameter int NCH = 16,
  parameter int AW  = 6,
  parameter int BW  = 4,
  parameter int TWR = 4,
  parameter int TRD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           io_en,
  input  logic [1:0]     io_model,
  input  logic [AW-1:0]  base_addr,
  input  logic [BW-1:0]  burst_len,
  input  logic [NCH-1:0] wr_data,
  input  logic [NCH-1:0] rd_data_in,
  output logic           add_in,
  output logic           add_valid,
  output logic [NCH-1:0] d_in,
  output logic           data_valid,
  output logic           wri_en,
  output logic           rd_en,
  output logic           vsaen,
  output logic [NCH-1:0] rd_data,
  output logic           rd_valid,
  output logic           wt_done,
  output logic           rd_done,
  output logic           busy,
  output logic           err,
  output logic [BW:0]    mismatch_cnt
);

  localparam int CW = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WRITE, S_READ, S_NEXT, S_DONE
  } state_t;

  state_t          r_state, w_nxt;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_mode;
  logic [AW-1:0]   r_base;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_sh;
  logic [BW-1:0]   r_blen;
  logic [BW-1:0]   r_k;
  logic [NCH-1:0]  r_wdat;
  logic            r_rdpass;
  logic [NCH-1:0]  r_rd_data;
  logic            r_err;
  logic [BW:0]     r_mcnt;

  logic [NCH-1:0]  w_pat;
  logic            w_accept;
  logic            w_last_word;
  logic            w_rd_last;

  // Upper half of {v,v} shifted left by s is v rotated left by s (s < NCH).
  function automatic logic [NCH-1:0] rotl(input logic [NCH-1:0] v, input int s);
    logic [2*NCH-1:0] d;
    d = {v, v} << s;
    return d[2*NCH-1:NCH];
  endfunction

  assign w_pat       = rotl(r_wdat, int'(r_k) % NCH);
  assign w_accept    = (r_state == S_IDLE) && io_en && (io_model != 2'b00);
  assign w_last_word = (r_k == r_blen);
  assign w_rd_last   = (r_state == S_READ) && (r_cnt == CW'(TRD - 1));

  always_comb begin
    w_nxt      = r_state;
    add_in     = 1'b0;
    add_valid  = 1'b0;
    d_in       = '0;
    data_valid = 1'b0;
    wri_en     = 1'b0;
    rd_en      = 1'b0;
    vsaen      = 1'b0;
    rd_valid   = 1'b0;
    wt_done    = 1'b0;
    rd_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_nxt = S_ADDR;
      end
      S_ADDR: begin
        add_valid = 1'b1;
        add_in    = r_sh[AW-1];
        if (r_cnt == CW'(AW - 1)) w_nxt = r_rdpass ? S_READ : S_WRITE;
      end
      S_WRITE: begin
        data_valid = 1'b1;
        wri_en     = 1'b1;
        d_in       = w_pat;
        if (r_cnt == CW'(TWR - 1)) w_nxt = S_NEXT;
      end
      S_READ: begin
        rd_en = 1'b1;
        vsaen = w_rd_last;
        if (w_rd_last) w_nxt = S_NEXT;
      end
      S_NEXT: begin
        rd_valid = r_rdpass;
        if (!w_last_word)                         w_nxt = S_ADDR;
        else if (r_mode == 2'b11 && !r_rdpass)    w_nxt = S_ADDR;
        else                                      w_nxt = S_DONE;
      end
      S_DONE: begin
        wt_done = r_mode[0];
        rd_done = r_mode[1];
        w_nxt   = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mode    <= 2'b00;
      r_base    <= '0;
      r_addr    <= '0;
      r_sh      <= '0;
      r_blen    <= '0;
      r_k       <= '0;
      r_wdat    <= '0;
      r_rdpass  <= 1'b0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
      r_mcnt    <= '0;
    end else begin
      r_state <= w_nxt;
      // Phase counter restarts on every state change.
      r_cnt   <= (w_nxt != r_state) ? '0 : r_cnt + 1'b1;

      if (w_accept) begin
        r_mode   <= io_model;
        r_base   <= base_addr;
        r_addr   <= base_addr;
        r_sh     <= base_addr;
        r_blen   <= burst_len;
        r_wdat   <= wr_data;
        r_k      <= '0;
        r_rdpass <= (io_model == 2'b10);
        r_err    <= 1'b0;
        r_mcnt   <= '0;
      end

      if (r_state == S_ADDR) r_sh <= r_sh << 1;

      if (w_rd_last) begin
        r_rd_data <= rd_data_in;
        if (r_mode == 2'b11 && rd_data_in != w_pat) begin
          r_err <= 1'b1;
          if (r_mcnt != '1) r_mcnt <= r_mcnt + 1'b1;
        end
      end

      if (r_state == S_NEXT) begin
        if (!w_last_word) begin
          r_addr <= r_addr + 1'b1;
          r_sh   <= r_addr + 1'b1;
          r_k    <= r_k + 1'b1;
        end else if (r_mode == 2'b11 && !r_rdpass) begin
          // Write pass finished: rewind for the verify read pass.
          r_addr   <= r_base;
          r_sh     <= r_base;
          r_k      <= '0;
          r_rdpass <= 1'b1;
        end
      end
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign rd_data      = r_rd_data;
  assign err          = r_err;
  assign mismatch_cnt = r_mcnt;

endmodule

// File: tb/tb_dram_rw_seq.sv
// Purpose : directed self-checking bench for dram_rw_seq with a chip memory model.
// Latency : n/a (bench).
// Backpress: n/a (bench).
module tb_dram_rw_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_en;
  logic [1:0]  io_model;
  logic [5:0]  base_addr;
  logic [3:0]  burst_len;
  logic [15:0] wr_data;
  logic [15:0] rd_data_in;
  logic        add_in, add_valid, data_valid, wri_en, rd_en, vsaen;
  logic [15:0] d_in, rd_data;
  logic        rd_valid, wt_done, rd_done, busy, err;
  logic [4:0]  mismatch_cnt;

  dram_rw_seq dut (
    .clk(clk), .rst(rst), .io_en(io_en), .io_model(io_model),
    .base_addr(base_addr), .burst_len(burst_len), .wr_data(wr_data),
    .rd_data_in(rd_data_in), .add_in(add_in), .add_valid(add_valid),
    .d_in(d_in), .data_valid(data_valid), .wri_en(wri_en), .rd_en(rd_en),
    .vsaen(vsaen), .rd_data(rd_data), .rd_valid(rd_valid), .wt_done(wt_done),
    .rd_done(rd_done), .busy(busy), .err(err), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-command observations
  logic [31:0] astream;
  int          nbits, wrc, nw, nr, wt_cyc, rd_cyc, rdv_first, busyc, finished;
  logic [15:0] wd [16];
  logic [15:0] rv [16];
  logic [15:0] mem [64];
  logic [5:0]  sh;
  logic        prev_wri;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {add_in, add_valid, d_in, data_valid, wri_en, rd_en, vsaen,
            rd_data, rd_valid, wt_done, rd_done, busy, err, mismatch_cnt};
  endfunction

  // src=1: chips echo memory contents; src=0: chips return cval.
  task automatic run(input logic [1:0] mode, input logic [5:0] base, input logic [3:0] blen,
                     input logic [15:0] wdat, input int src, input logic [15:0] cval,
                     input int inj_cyc, input int rst_cyc);
    astream = '0; nbits = 0; wrc = 0; nw = 0; nr = 0; wt_cyc = 0; rd_cyc = 0;
    rdv_first = 0; busyc = 0; finished = 0; prev_wri = 1'b0; sh = '0;
    @(negedge clk);
    io_en = 1'b1; io_model = mode; base_addr = base; burst_len = blen; wr_data = wdat;
    rd_data_in = cval;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      // Scramble command inputs to show they were latched.
      io_en = 1'b0; io_model = 2'b00; base_addr = 6'h2A; burst_len = 4'hF; wr_data = 16'h0;
      if (add_valid) begin
        astream = {astream[30:0], add_in};
        nbits++;
        sh = {sh[4:0], add_in};
      end
      if (wri_en) begin
        if (!prev_wri) begin wd[nw] = d_in; nw++; end
        wrc++;
        mem[sh] = d_in;
      end
      prev_wri = wri_en;
      if (rd_valid) begin
        if (nr == 0) rdv_first = c;
        rv[nr] = rd_data;
        nr++;
      end
      if (wt_done && wt_cyc == 0) wt_cyc = c;
      if (rd_done && rd_cyc == 0) rd_cyc = c;
      if (busy) busyc++;
      rd_data_in = (src != 0) ? mem[sh] : cval;
      if (c == inj_cyc) begin io_en = 1'b1; io_model = 2'b10; burst_len = 4'h0; end
      if (c == rst_cyc) rst = 1'b1;
      if (rst_cyc != 0 && c == rst_cyc + 1) begin
        chk("outs_zero_after_rst", all_outs(), 64'h0);
        rst = 1'b0;
      end
      if (!busy && c >= 2) begin finished = 1; break; end
    end
    chk("cmd_terminates", finished, 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1'b1; io_en = 1'b0; io_model = 2'b00; base_addr = '0; burst_len = '0;
    wr_data = '0; rd_data_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 64'h0);
    rst = 1'b0;

    // Write, base 05, single word A5A5
    run(2'b01, 6'h05, 4'd0, 16'hA5A5, 0, 16'h0, 0, 0);
    chk("wr_addr_bits", {nbits, astream}, {32'd6, 32'h05});
    chk("wr_word0", wd[0], 16'hA5A5);
    chk("wr_cycles", wrc, 4);
    chk("wr_done_cyc", wt_cyc, 12);
    chk("wr_no_rd_done", rd_cyc, 0);

    // Read, base 3F, two words, address wraps to 00
    run(2'b10, 6'h3F, 4'd1, 16'h0, 0, 16'h1234, 0, 0);
    chk("rd_addr_bits", {nbits, astream}, {32'd12, 32'hFC0});
    chk("rd_valid_cnt", nr, 2);
    chk("rd_valid_first", rdv_first, 11);
    chk("rd_done_cyc", rd_cyc, 23);
    chk("rd_no_wt_done", wt_cyc, 0);
    chk("rd_no_write", wrc, 0);
    chk("rd_data_hold", rd_data, 16'h1234);

    // Verify with echoing chips: patterns 0001, 0002, 0004
    run(2'b11, 6'h10, 4'd2, 16'h0001, 1, 16'h0, 0, 0);
    chk("vf_wr_words", {wd[0], wd[1], wd[2]}, {16'h0001, 16'h0002, 16'h0004});
    chk("vf_rd_words", {rv[0], rv[1], rv[2]}, {16'h0001, 16'h0002, 16'h0004});
    chk("vf_err", {err, mismatch_cnt}, 6'h0);
    chk("vf_wt_done_cyc", wt_cyc, 67);
    chk("vf_rd_done_cyc", rd_cyc, 67);

    // Verify with chips stuck at zero: every word mismatches
    run(2'b11, 6'h20, 4'd3, 16'h0003, 0, 16'h0, 0, 0);
    chk("vf0_err", err, 1);
    chk("vf0_mcnt", mismatch_cnt, 4);
    chk("vf0_done_cyc", rd_cyc, 89);

    // io_model=00 in IDLE is ignored
    @(negedge clk); io_en = 1'b1; io_model = 2'b00;
    @(negedge clk); io_en = 1'b0;
    chk("nop_not_busy", busy, 0);
    @(negedge clk);
    chk("nop_still_idle", {busy, wt_done, rd_done}, 3'b000);

    // Write burst with a read command pulsed mid-burst
    run(2'b01, 6'h01, 4'd1, 16'h8001, 0, 16'h0, 5, 0);
    chk("inj_done_cyc", wt_cyc, 23);
    chk("inj_no_rd_done", rd_cyc, 0);
    chk("inj_busy_cycles", busyc, 23);
    chk("inj_words", {wd[0], wd[1]}, {16'h8001, 16'h0003});
    chk("new_cmd_clears_err", {err, mismatch_cnt}, 6'h0);

    // Reset in the middle of WRITE, then a fresh read
    run(2'b01, 6'h08, 4'd0, 16'hFFFF, 0, 16'h0, 0, 8);
    chk("rst_no_wt_done", wt_cyc, 0);
    chk("rst_rd_data_clr", rd_data, 16'h0);
    run(2'b10, 6'h02, 4'd0, 16'h0, 0, 16'hBEEF, 0, 0);
    chk("post_rst_rd_done", rd_cyc, 12);
    chk("post_rst_rd_data", rd_data, 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
